// File: rtl/serdes_pkg.sv
// serdes_pkg: shared constants and FSM state type for the serial link.
package serdes_pkg;
  localparam int DATA_W_DEFAULT = 8;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush and occupancy count.
// Ports: push/wdata write side (ignored when full), pop/rdata read side (rdata shows
// the head, ignored when empty), flush empties the buffer with priority over push/pop,
// full/empty/level report occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign level = cnt_q;
  assign rdata = mem_q[rd_q];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: buffers samples in a FIFO and shifts them out MSB-first, back-to-back.
// Ports: in_data/in_valid/in_ready upstream handshake, flush synchronous abort,
// serial_out/serial_valid bit stream with qualifier, frame_start marks each MSB,
// fifo_level FIFO occupancy.
module byte_serializer
  import serdes_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          serial_out,
  output logic                          serial_valid,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(DATA_W);
  ser_state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, head;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full, empty, pop, last;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(in_valid), .wdata(in_data),
    .pop(pop), .rdata(head),
    .flush(flush), .full(full), .empty(empty), .level(fifo_level)
  );
  assign in_ready = !full;
  assign last = cnt_q == '0;
  // Reloading on the last bit keeps queued bytes gapless on the wire.
  assign pop = !flush && !empty && (state_q == IDLE || last);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = flush ? IDLE : pop ? SHIFT : (state_q == SHIFT && last) ? IDLE : state_q;
    shift_d = pop ? head : {shift_q[DATA_W-2:0], 1'b0};
    cnt_d = pop ? CW'(DATA_W-1) : cnt_q - 1'b1;
  end
  always_comb begin
    serial_valid = state_q == SHIFT;
    serial_out = serial_valid && shift_q[DATA_W-1];
    frame_start = serial_valid && cnt_q == CW'(DATA_W-1);
  end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed self-checking bench for byte_serializer.
module tb_byte_serializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic flush = 1'b0;
  logic serial_out, serial_valid, frame_start;
  logic [2:0] fifo_level;
  int checks = 0;
  int fails = 0;
  logic [7:0] rx_sh;
  int rx_n;
  logic [7:0] rx_q[$];

  byte_serializer dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .serial_out(serial_out),
    .serial_valid(serial_valid), .frame_start(frame_start), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_clear;
    rx_n = 0;
    rx_sh = '0;
    rx_q.delete();
  endtask

  task automatic rx_sample;
    if (serial_valid) begin
      rx_sh = {rx_sh[6:0], serial_out};
      rx_n++;
      if (rx_n % 8 == 0) rx_q.push_back(rx_sh);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (serial_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", serial_valid); end
    checks++; if (serial_out !== 1'b0) begin fails++; $display("FAIL reset_out got=%b exp=0", serial_out); end
    checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single;
    logic [7:0] b;
    b = 8'hA5;
    in_data = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL single_level_push got=%0d exp=1", fifo_level); end
    checks++; if (serial_valid !== 1'b0) begin fails++; $display("FAIL single_valid_early got=%b exp=0", serial_valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (serial_valid !== 1'b1) begin fails++; $display("FAIL single_valid bit%0d got=%b exp=1", i, serial_valid); end
      checks++; if (serial_out !== b[7-i]) begin fails++; $display("FAIL single_bit bit%0d got=%b exp=%b", i, serial_out, b[7-i]); end
      checks++; if (frame_start !== (i == 0)) begin fails++; $display("FAIL single_fs bit%0d got=%b exp=%b", i, frame_start, i == 0); end
    end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL single_level_pop got=%0d exp=0", fifo_level); end
    tick();
    checks++; if (serial_valid !== 1'b0) begin fails++; $display("FAIL single_idle got=%b exp=0", serial_valid); end
    checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL single_idle_fs got=%b exp=0", frame_start); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [3];
    int first, last_c, fs_bad;
    vals = '{8'h80, 8'h7F, 8'hFF};
    first = -1;
    last_c = -1;
    fs_bad = 0;
    rx_clear();
    for (int c = 0; c < 32; c++) begin
      in_valid = c < 3;
      if (c < 3) in_data = vals[c];
      tick();
      rx_sample();
      if (serial_valid) begin
        if (first < 0) first = c;
        last_c = c;
        if (frame_start !== (rx_n % 8 == 1)) fs_bad++;
      end else if (frame_start !== 1'b0) fs_bad++;
    end
    in_valid = 1'b0;
    checks++; if (first !== 1) begin fails++; $display("FAIL b2b_first got=%0d exp=1", first); end
    checks++; if (last_c - first + 1 !== 24 || rx_n !== 24) begin fails++; $display("FAIL b2b_contiguous span=%0d bits=%0d exp=24", last_c - first + 1, rx_n); end
    checks++; if (fs_bad !== 0) begin fails++; $display("FAIL b2b_frame_start bad_cycles=%0d exp=0", fs_bad); end
    checks++; if (rx_q.size() !== 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= rx_q.size() || rx_q[i] !== vals[i]) begin fails++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, vals[i]); end
    end
    repeat (2) tick();
  endtask

  task automatic test_full;
    int acc;
    bit seen_full, will;
    acc = 0;
    seen_full = 0;
    rx_clear();
    for (int c = 0; c < 60; c++) begin
      in_valid = acc < 5;
      in_data = 8'h10 + 8'(acc);
      will = in_valid && in_ready;
      tick();
      if (will) acc++;
      rx_sample();
      if (!in_ready && !seen_full) begin
        seen_full = 1;
        checks++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
        checks++; if (acc !== 5) begin fails++; $display("FAIL full_accepted got=%0d exp=5", acc); end
      end
    end
    in_valid = 1'b0;
    checks++; if (!seen_full) begin fails++; $display("FAIL full_ready_drop got=never exp=drop"); end
    checks++; if (rx_q.size() !== 5) begin fails++; $display("FAIL full_count got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (i >= rx_q.size() || rx_q[i] !== 8'h10 + 8'(i)) begin fails++; $display("FAIL full_byte%0d got=%h exp=%h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, 8'h10 + 8'(i)); end
    end
    repeat (2) tick();
  endtask

  task automatic test_flush;
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    in_data = 8'hAA;
    tick();
    in_data = 8'hBB;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL flush_queued got=%0d exp=2", fifo_level); end
    checks++; if (serial_valid !== 1'b1 || serial_out !== 1'b1) begin fails++; $display("FAIL flush_bit3 got=%b%b exp=11", serial_valid, serial_out); end
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (serial_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%b exp=0", serial_valid); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL flush_level got=%0d exp=0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (serial_valid !== 1'b0) begin fails++; $display("FAIL flush_stays_idle got=%b exp=0", serial_valid); end
    rx_clear();
    in_valid = 1'b1;
    in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      rx_sample();
    end
    checks++; if (rx_q.size() !== 1 || rx_n !== 8) begin fails++; $display("FAIL flush_after_count got=%0d bits=%0d exp=1 bits=8", rx_q.size(), rx_n); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h01) begin fails++; $display("FAIL flush_after_byte got=%h exp=01", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1;
    in_data = 8'hC3;
    tick();
    in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    checks++; if (serial_valid !== 1'b1 || serial_out !== 1'b1 || frame_start !== 1'b1 || fifo_level !== 3'd1) begin fails++; $display("FAIL rstmid_pre got=v%b o%b f%b l%0d exp=v1 o1 f1 l1", serial_valid, serial_out, frame_start, fifo_level); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (serial_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%b exp=0", serial_valid); end
    checks++; if (serial_out !== 1'b0) begin fails++; $display("FAIL rstmid_out got=%b exp=0", serial_out); end
    checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL rstmid_fs got=%b exp=0", frame_start); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rstmid_level got=%0d exp=0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    tick();
    reset_n = 1'b1;
    tick();
    rx_clear();
    in_valid = 1'b1;
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      rx_sample();
    end
    checks++; if (rx_q.size() !== 1 || rx_n !== 8) begin fails++; $display("FAIL rstmid_after_count got=%0d bits=%0d exp=1 bits=8", rx_q.size(), rx_n); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h55) begin fails++; $display("FAIL rstmid_after_byte got=%h exp=55", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
    repeat (2) tick();
  endtask

  task automatic test_simul_push_pop;
    logic [7:0] exp_b [3];
    exp_b = '{8'hA1, 8'hB2, 8'hC3};
    rx_clear();
    for (int c = 0; c < 40; c++) begin
      in_valid = (c == 0 || c == 1 || c == 9);
      in_data = c == 0 ? 8'hA1 : c == 1 ? 8'hB2 : 8'hC3;
      tick();
      rx_sample();
      if (c == 8) begin
        checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL simul_level_before got=%0d exp=1", fifo_level); end
      end
      if (c == 1 || c == 9) begin
        checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL simul_level_c%0d got=%0d exp=1", c, fifo_level); end
      end
    end
    in_valid = 1'b0;
    checks++; if (rx_q.size() !== 3 || rx_n !== 24) begin fails++; $display("FAIL simul_count got=%0d bits=%0d exp=3 bits=24", rx_q.size(), rx_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin fails++; $display("FAIL simul_byte%0d got=%h exp=%h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_flush();
    test_reset_mid();
    test_simul_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/byte_serializer.md
# byte_serializer

Upstream stage of the serial link: accepts signed 8-bit samples over a valid/ready handshake, buffers them in a small FIFO and shifts each one out MSB-first on a single wire. Alongside the wire it drives a qualifying enable, `serial_valid`, which connects directly to the receiver's start/enable input. Consecutive bytes go out back-to-back with no idle cycle, so the receiver's bit counter never sees a gap inside or between queued bytes.

## Interface
- `DATA_W`, 8: sample width and bits per frame.
- `FIFO_DEPTH`, 4: input buffer entries; power of two, at least 2.
- `clk`  in  1  single clock; everything samples on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  signed sample; accepted when `in_valid && in_ready`.
- `in_valid`  in  1  upstream has a sample.
- `in_ready`  out  1  equals `!fifo_full`; there is no bypass path.
- `flush`  in  1  synchronous abort: clears the FIFO and the byte currently being shifted.
- `serial_out`  out  1  current bit, MSB first.
- `serial_valid`  out  1  high for every cycle that carries a frame bit; drives the receiver's start/enable.
- `frame_start`  out  1  one-cycle pulse coincident with bit 7 of each byte.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- FSM has two states: IDLE and SHIFT.
- **IDLE**
  - `serial_valid`=0 and `serial_out`=0.
  - If the FIFO is non-empty: pop the head into `shift_reg`, set `bit_cnt`=DATA_W-1, go to SHIFT.
- **SHIFT**
  - `serial_out`=`shift_reg[DATA_W-1]` and `serial_valid`=1.
  - Each cycle: shift `shift_reg` left by one (zero fill) and decrement `bit_cnt`.
  - When `bit_cnt`==0 and the FIFO is non-empty: pop and reload in the same cycle, stay in SHIFT, `frame_start` pulses on the next cycle.
  - When `bit_cnt`==0 and the FIFO is empty: go to IDLE.
- `frame_start`=1 exactly on cycles where SHIFT is active and `bit_cnt`==DATA_W-1.
- **FIFO**
  - A push and a pop in the same cycle leave `fifo_level` unchanged.
  - A push is only possible when not full, because `in_ready` gates it.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Flush**
  - On the next edge: FIFO is emptied, FSM goes to IDLE, `serial_valid` goes low. A partial byte is abandoned.
  - A push presented in the same cycle as `flush` is discarded.
  - Flush has priority over both push and pop.
- **Reset** (asynchronous, may land mid-operation): every output is 0 immediately, except `in_ready`, which is 1. State returns to IDLE and the FIFO is emptied. On release, operation restarts cleanly on the next edge.
- Data is passed through bit-exact; the block applies no sign handling.

## Timing
- Latency, IDLE with an empty FIFO:
  - Accepted at edge N → popped at edge N+1.
  - First bit (MSB) on `serial_out` during cycle N+2.
  - LSB during cycle N+9.
- Throughput with the FIFO non-empty: one byte per DATA_W cycles; `serial_valid` stays continuously high.
- `in_ready` and `fifo_level` update one cycle after a push or pop.
- `serial_out` and `serial_valid` are driven from registers; there is no combinational path from any input.

## Structure
- Package `serdes_pkg`:
  - `DATA_W` default.
  - `ser_state_t` enum {IDLE, SHIFT}.
- Sub-module `sync_fifo`:
  - Parameters: width, depth.
  - Ports: push, pop, flush, full, empty, level.
  - Reusable by the receive side.
- Top level contains the FSM, the shift register and the bit counter.

## Test plan
- **Single byte:** push 8'hA5 from reset → `serial_valid` high for cycles N+2..N+9, bits 1,0,1,0,0,1,0,1, `frame_start` only at N+2, then IDLE.
- **Back-to-back:** push 8'h80, 8'h7F, 8'hFF consecutively → `serial_valid` high for 24 contiguous cycles, `frame_start` every 8 cycles. A looped-back receiver (shift register clocked while `serial_valid` is high, sampled every 8 bits) recovers 80, 7F, FF.
- **Full:** hold `in_valid` with the consumer in progress → `in_ready` drops when `fifo_level`==4 (5 bytes accepted including the one being shifted). No data is lost and all bytes are emitted in order.
- **Flush mid-byte:** assert `flush` at bit 3 of 8'h3C with 2 entries queued → next cycle `serial_valid`=0 and `fifo_level`=0; a subsequent push of 8'h01 serializes correctly.
- **Reset mid-byte:** drop `reset_n` asynchronously during SHIFT → outputs are 0 and `in_ready`=1 before the next edge; after release, a push of 8'h55 emits 0,1,0,1,0,1,0,1.
- **Simultaneous push/pop:** push on the exact cycle the FSM pops, at `fifo_level`==1 → level stays 1, order is preserved.
